// File: rtl/light_pkg.sv
// -----------------------------------------------------------------------------
// light_pkg
// Shared types and constants for the light level sequencer.
//   LEVEL_W / LEVEL_MAX : width and ceiling of a brightness value
//   src_e               : which requester currently owns the light
//   ramp_state_e        : ramp FSM states
//   ramp_classify()     : derives the ramp state from delivered level vs target
// -----------------------------------------------------------------------------
package light_pkg;

    localparam int                 LEVEL_W   = 4;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'b00,
        SRC_MOTION = 2'b01,
        SRC_MANUAL = 2'b10
    } src_e;

    typedef enum logic [1:0] {
        RAMP_OFF,
        RAMP_RISE,
        RAMP_ON,
        RAMP_FALL
    } ramp_state_e;

    // The ramp state is a pure function of where the light is and where it
    // should be, so a target change is reflected in the same cycle.
    function automatic ramp_state_e ramp_classify(
        input logic [LEVEL_W-1:0] level,
        input logic [LEVEL_W-1:0] target
    );
        ramp_state_e st;
        if (level < target)
            st = RAMP_RISE;
        else if (level > target)
            st = RAMP_FALL;
        else if (level == '0)
            st = RAMP_OFF;
        else
            st = RAMP_ON;
        return st;
    endfunction

endpackage

// File: rtl/light_ramp.sv
// -----------------------------------------------------------------------------
// light_ramp
// Moves the delivered brightness one LSB every STEP_CYCLES clocks toward the
// registered target.
//   clk    : rising-edge clock
//   rst    : synchronous, active-high reset
//   target : brightness to ramp toward
//   level  : delivered brightness (registered)
//   busy   : high while level differs from target (RISE or FALL)
// -----------------------------------------------------------------------------
module light_ramp
    import light_pkg::*;
#(
    parameter int STEP_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LEVEL_W-1:0] target,
    output logic [LEVEL_W-1:0] level,
    output logic               busy
);

    localparam int             CNT_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    ramp_state_e        state;
    ramp_state_e        state_q;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0]   step_cnt, step_cnt_d, step_cnt_eff;
    logic               reversal;

    // State register.
    // NOTE: reset is synchronous here, so it sits inside the clocked branch
    // and never appears in the sensitivity list.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            state_q  <= RAMP_OFF;
            level_q  <= '0;
            step_cnt <= '0;
        end else begin
            state_q  <= state;
            level_q  <= level_d;
            step_cnt <= step_cnt_d;
        end
    end

    // Next-state / output logic.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave it unassigned and infer a latch.
        state        = ramp_classify(level_q, target);
        level_d      = level_q;
        step_cnt_d   = '0;
        step_cnt_eff = step_cnt;
        reversal     = ((state == RAMP_RISE) && (state_q == RAMP_FALL)) ||
                       ((state == RAMP_FALL) && (state_q == RAMP_RISE));

        // On a direction reversal the partial step taken toward the old target
        // is discarded: this cycle counts as step 0 of the new direction, the
        // same as starting a ramp from OFF or ON.
        if (reversal)
            step_cnt_eff = '0;

        unique case (state)
            RAMP_RISE, RAMP_FALL: begin
                if (step_cnt_eff == CNT_LAST) begin
                    step_cnt_d = '0;
                    // level only ever moves toward target, so these guards
                    // never bind; they document that the value cannot wrap.
                    if (state == RAMP_RISE) begin
                        if (level_q != LEVEL_MAX)
                            level_d = level_q + 1'b1;
                    end else begin
                        if (level_q != '0)
                            level_d = level_q - 1'b1;
                    end
                end else begin
                    step_cnt_d = step_cnt_eff + 1'b1;
                end
            end
            default: step_cnt_d = '0;
        endcase
    end

    assign level = level_q;
    assign busy  = (state == RAMP_RISE) || (state == RAMP_FALL);

endmodule

// File: rtl/light_level_sequencer.sv
// -----------------------------------------------------------------------------
// light_level_sequencer
// Owns the brightness input of light_controller. Arbitrates a manual override
// against night-gated motion lighting (manual wins), holds motion light for
// HOLD_CYCLES after the last detection, and ramps the delivered level.
//   clk          : rising-edge clock
//   rst          : synchronous, active-high reset
//   manual_req   : level-sensitive manual override
//   manual_level : manual target brightness
//   motion_det   : motion sensor; each high cycle re-arms the hold timer
//   motion_level : brightness used for motion lighting
//   night        : motion lighting allowed only while high
//   level_out    : delivered brightness
//   src          : current owner (00 none, 01 motion, 10 manual)
//   busy         : high while level_out is ramping toward target
// -----------------------------------------------------------------------------
module light_level_sequencer
    import light_pkg::*;
#(
    parameter int STEP_CYCLES = 4,
    parameter int HOLD_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               manual_req,
    input  logic [LEVEL_W-1:0] manual_level,
    input  logic               motion_det,
    input  logic [LEVEL_W-1:0] motion_level,
    input  logic               night,
    output logic [LEVEL_W-1:0] level_out,
    output logic [1:0]         src,
    output logic               busy
);

    localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    logic [HOLD_W-1:0]  hold_cnt;
    logic               motion_active;
    logic [LEVEL_W-1:0] target, target_d;
    src_e               src_q, src_d;

    // Hold timer: reload on every detection, otherwise count down to zero.
    // It runs in daylight too, so motion just before dusk still lights.
    always_ff @(posedge clk) begin
        if (rst)
            hold_cnt <= '0;
        else if (motion_det)
            hold_cnt <= HOLD_LOAD;
        else if (hold_cnt != '0)
            hold_cnt <= hold_cnt - 1'b1;
    end

    // A detection counts in the cycle it arrives, so target follows the input
    // after exactly one clock, and a re-arm on the expiring cycle leaves no gap.
    assign motion_active = motion_det || (hold_cnt != '0);

    always_comb begin
        target_d = '0;
        src_d    = SRC_NONE;
        if (manual_req) begin
            target_d = manual_level;
            src_d    = SRC_MANUAL;
        end else if (motion_active && night) begin
            target_d = motion_level;
            src_d    = SRC_MOTION;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target <= '0;
            src_q  <= SRC_NONE;
        end else begin
            target <= target_d;
            src_q  <= src_d;
        end
    end

    assign src = src_q;

    light_ramp #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_ramp (
        .clk    (clk),
        .rst    (rst),
        .target (target),
        .level  (level_out),
        .busy   (busy)
    );

endmodule

// File: tb/tb_light_level_sequencer.sv
// -----------------------------------------------------------------------------
// tb_light_level_sequencer
// Directed stimulus with hand-computed expectations. The stimulus process
// pushes (cycle, level, src, busy) entries into a scoreboard queue; a monitor
// on the falling edge pops every entry due that cycle and compares.
// Cycle numbering: inputs driven just after rising edge k take effect at
// edge k+1; outputs are sampled on the falling edge of each cycle.
// -----------------------------------------------------------------------------
module tb_light_level_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       manual_req;
    logic [3:0] manual_level;
    logic       motion_det;
    logic [3:0] motion_level;
    logic       night;
    logic [3:0] level_out;
    logic [1:0] src;
    logic       busy;

    light_level_sequencer #(
        .STEP_CYCLES (4),
        .HOLD_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .manual_req   (manual_req),
        .manual_level (manual_level),
        .motion_det   (motion_det),
        .motion_level (motion_level),
        .night        (night),
        .level_out    (level_out),
        .src          (src),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] level;
        logic [1:0] src;
        logic       busy;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   c0     = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, act, req);
        end
    endtask

    // Monitor: compare every expectation that falls due this cycle.
    exp_t e;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                n_vec++;
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", e.name, e.cyc, cyc);
            end else begin
                check({e.name, ".level"}, level_out, e.level);
                check({e.name, ".src"},   {2'b00, src},  {2'b00, e.src});
                check({e.name, ".busy"},  {3'b000, busy}, {3'b000, e.busy});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        c0 = cyc;
    endtask

    task automatic until_rel(input int rel);
        while (cyc < c0 + rel) tick();
    endtask

    task automatic expect_at(input int rel, input logic [3:0] lvl, input logic [1:0] s,
                             input logic b, input string nm);
        exp_t x;
        x.cyc   = c0 + rel;
        x.level = lvl;
        x.src   = s;
        x.busy  = b;
        x.name  = nm;
        sb.push_back(x);
    endtask

    initial begin
        rst          = 1'b1;
        manual_req   = 1'b0;
        manual_level = 4'd0;
        motion_det   = 1'b0;
        motion_level = 4'd0;
        night        = 1'b0;
        tick();

        // 1. Reset held two cycles with inputs toggling; reset must win.
        start();
        expect_at(0, 4'd0, 2'b00, 1'b0, "rst_c0");
        expect_at(1, 4'd0, 2'b00, 1'b0, "rst_c1");
        expect_at(2, 4'd0, 2'b00, 1'b0, "rst_c2");
        expect_at(3, 4'd0, 2'b00, 1'b0, "rst_release");
        expect_at(4, 4'd0, 2'b00, 1'b0, "rst_release+1");
        manual_req = 1'b1; manual_level = 4'd15; motion_det = 1'b1;
        motion_level = 4'd15; night = 1'b1;
        tick();
        manual_req = 1'b0; manual_level = 4'd5;
        tick();
        rst = 1'b0; motion_det = 1'b0;
        until_rel(5);
        night = 1'b0;

        // 2. Manual ramp 0 -> 3, then release and fade back to 0.
        start();
        manual_req = 1'b1; manual_level = 4'd3;
        expect_at(1,  4'd0, 2'b10, 1'b1, "man_src");
        expect_at(4,  4'd0, 2'b10, 1'b1, "man_pre_step");
        expect_at(5,  4'd1, 2'b10, 1'b1, "man_l1");
        expect_at(9,  4'd2, 2'b10, 1'b1, "man_l2");
        expect_at(12, 4'd2, 2'b10, 1'b1, "man_pre_l3");
        expect_at(13, 4'd3, 2'b10, 1'b0, "man_l3_done");
        expect_at(16, 4'd3, 2'b10, 1'b0, "man_hold");
        expect_at(18, 4'd3, 2'b00, 1'b1, "man_release");
        expect_at(22, 4'd2, 2'b00, 1'b1, "man_fall_l2");
        expect_at(30, 4'd0, 2'b00, 1'b0, "man_fall_l0");
        expect_at(32, 4'd0, 2'b00, 1'b0, "man_floor");
        until_rel(17);
        manual_req = 1'b0;
        until_rel(33);

        // 3. Single motion pulse at night: light, hold, expire, fade.
        start();
        night = 1'b1; motion_level = 4'd2; motion_det = 1'b1;
        expect_at(1,  4'd0, 2'b01, 1'b1, "mot_src");
        expect_at(5,  4'd1, 2'b01, 1'b1, "mot_l1");
        expect_at(9,  4'd2, 2'b01, 1'b0, "mot_l2");
        expect_at(17, 4'd2, 2'b01, 1'b0, "mot_last_hold");
        expect_at(18, 4'd2, 2'b00, 1'b1, "mot_expire");
        expect_at(21, 4'd2, 2'b00, 1'b1, "mot_pre_fall");
        expect_at(22, 4'd1, 2'b00, 1'b1, "mot_fall_l1");
        expect_at(26, 4'd0, 2'b00, 1'b0, "mot_fall_l0");
        tick();
        motion_det = 1'b0;
        until_rel(28);
        night = 1'b0;

        // 4. Motion in daylight: nothing lights.
        start();
        motion_level = 4'd9;
        expect_at(1,  4'd0, 2'b00, 1'b0, "day_p1");
        expect_at(4,  4'd0, 2'b00, 1'b0, "day_p2");
        expect_at(8,  4'd0, 2'b00, 1'b0, "day_p3");
        expect_at(12, 4'd0, 2'b00, 1'b0, "day_after");
        for (int p = 0; p < 3; p++) begin
            until_rel(3 * p);
            motion_det = 1'b1;
            tick();
            motion_det = 1'b0;
        end
        until_rel(26);

        // 5. Motion steady at 2, manual takes over to 6, manual dropped at 4
        //    (reversal), then night falls while motion-lit.
        start();
        night = 1'b1; motion_level = 4'd2; motion_det = 1'b1;
        expect_at(9,  4'd2, 2'b01, 1'b0, "pri_mot_steady");
        expect_at(11, 4'd2, 2'b10, 1'b1, "pri_manual_wins");
        expect_at(15, 4'd3, 2'b10, 1'b1, "pri_l3");
        expect_at(19, 4'd4, 2'b10, 1'b1, "pri_l4");
        expect_at(20, 4'd4, 2'b01, 1'b1, "rev_src");
        expect_at(23, 4'd4, 2'b01, 1'b1, "rev_no_early_step");
        expect_at(24, 4'd3, 2'b01, 1'b1, "rev_l3");
        expect_at(28, 4'd2, 2'b01, 1'b0, "rev_l2_done");
        expect_at(30, 4'd2, 2'b00, 1'b1, "dusk_end_src");
        expect_at(34, 4'd1, 2'b00, 1'b1, "dusk_l1");
        expect_at(38, 4'd0, 2'b00, 1'b0, "dusk_l0");
        until_rel(10);
        manual_req = 1'b1; manual_level = 4'd6;
        until_rel(19);
        manual_req = 1'b0;
        until_rel(29);
        night = 1'b0;
        until_rel(30);
        motion_det = 1'b0;
        until_rel(40);

        // 6. Reset mid-ramp at level 7, then a full sweep 0 -> 15.
        start();
        manual_req = 1'b1; manual_level = 4'd15;
        expect_at(28, 4'd6,  2'b10, 1'b1, "mid_l6");
        expect_at(29, 4'd7,  2'b10, 1'b1, "mid_l7");
        expect_at(30, 4'd0,  2'b00, 1'b0, "mid_rst");
        expect_at(31, 4'd0,  2'b10, 1'b1, "mid_rearm");
        expect_at(34, 4'd0,  2'b10, 1'b1, "mid_pre_l1");
        expect_at(35, 4'd1,  2'b10, 1'b1, "mid_l1");
        expect_at(90, 4'd14, 2'b10, 1'b1, "sweep_l14");
        expect_at(91, 4'd15, 2'b10, 1'b0, "sweep_l15");
        expect_at(95, 4'd15, 2'b10, 1'b0, "sweep_ceiling");
        until_rel(29);
        rst = 1'b1;
        until_rel(30);
        rst = 1'b0;
        until_rel(97);

        tick();
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
